// File: rtl/redun_mont_sqr_sequencer.sv
// Montgomery squaring loop sequencer: issues square / low-by-M' / high-by-M passes to the
// multiplier per iteration and returns the redundant result after i_iter squarings.
module redun_mont_sqr_sequencer #(
  parameter int unsigned NUM_ELEMENTS = 33,
  parameter int unsigned DSP_BIT_LEN  = 17,
  parameter int unsigned WORD_LEN     = 16,
  parameter int unsigned ITER_BITS    = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic [ITER_BITS-1:0]                  i_iter,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_dat,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_mod,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_mod_inv,
  output logic                                  o_mul_val,
  output logic [2*NUM_ELEMENTS-1:0]             o_mul_ctl,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_mul_a,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_mul_b,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_mul_add,
  input  logic [2*DSP_BIT_LEN*NUM_ELEMENTS-1:0] i_mul_dat,
  input  logic                                  i_mul_val,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_dat,
  output logic                                  o_val,
  output logic                                  o_busy
);

  localparam int unsigned DW = DSP_BIT_LEN * NUM_ELEMENTS;

  // Redundant words need at least one carry bit above the non-redundant payload.
  if (WORD_LEN >= DSP_BIT_LEN) begin : g_bad_word_len
    $error("WORD_LEN must be smaller than DSP_BIT_LEN");
  end

  typedef enum logic [2:0] {
    StIdle, StSqrIss, StSqrWait, StLoIss, StLoWait, StHiIss, StHiWait, StDone
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]            x_q, x_d, t_lo_q, t_lo_d, t_hi_q, t_hi_d, q_q, q_d;
  logic [ITER_BITS-1:0]     cnt_q, cnt_d;
  logic                     mul_val_q, mul_val_d;
  logic [2*NUM_ELEMENTS-1:0] mul_ctl_q, mul_ctl_d;
  logic [DW-1:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_add_q, mul_add_d;
  logic [DW-1:0]            dat_q, dat_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (i_start) state_d = (i_iter == '0) ? StDone : StSqrIss;
      StSqrIss:  state_d = StSqrWait;
      StSqrWait: if (i_mul_val) state_d = StLoIss;
      StLoIss:   state_d = StLoWait;
      StLoWait:  if (i_mul_val) state_d = StHiIss;
      StHiIss:   state_d = StHiWait;
      StHiWait:  if (i_mul_val) state_d = (cnt_q == ITER_BITS'(1)) ? StDone : StSqrIss;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    t_lo_d = t_lo_q;
    t_hi_d = t_hi_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          x_d   = i_dat;
          cnt_d = i_iter;
        end
      end
      StSqrWait: begin
        if (i_mul_val) begin
          t_lo_d = i_mul_dat[DW-1:0];
          t_hi_d = i_mul_dat[2*DW-1:DW];
        end
      end
      StLoWait: if (i_mul_val) q_d = i_mul_dat[DW-1:0];
      StHiWait: begin
        if (i_mul_val) begin
          x_d = i_mul_dat[2*DW-1:DW];
          if (cnt_q != '0) cnt_d = cnt_q - ITER_BITS'(1);
        end
      end
      default: ;
    endcase

    // Operand registers load on entry to an issue state and hold otherwise.
    mul_val_d = 1'b0;
    mul_ctl_d = mul_ctl_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_add_d = mul_add_q;
    case (state_d)
      StSqrIss: begin
        mul_val_d = 1'b1;
        mul_ctl_d = {NUM_ELEMENTS{2'd2}};
        mul_a_d   = x_d;
        mul_b_d   = x_d;
        mul_add_d = '0;
      end
      StLoIss: begin
        mul_val_d = 1'b1;
        mul_ctl_d = {NUM_ELEMENTS{2'd0}};
        mul_a_d   = t_lo_d;
        mul_b_d   = i_mod_inv;
        mul_add_d = '0;
      end
      StHiIss: begin
        mul_val_d = 1'b1;
        mul_ctl_d = {NUM_ELEMENTS{2'd1}};
        mul_a_d   = q_d;
        mul_b_d   = i_mod;
        mul_add_d = t_hi_d;
      end
      default: ;
    endcase

    dat_d = (state_d == StDone) ? x_d : dat_q;

    o_mul_val = mul_val_q;
    o_mul_ctl = mul_ctl_q;
    o_mul_a   = mul_a_q;
    o_mul_b   = mul_b_q;
    o_mul_add = mul_add_q;
    o_dat     = dat_q;
    o_val     = (state_q == StDone);
    o_busy    = (state_q != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q       <= '0;
      t_lo_q    <= '0;
      t_hi_q    <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      mul_val_q <= 1'b0;
      mul_ctl_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_add_q <= '0;
      dat_q     <= '0;
    end else begin
      x_q       <= x_d;
      t_lo_q    <= t_lo_d;
      t_hi_q    <= t_hi_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      mul_val_q <= mul_val_d;
      mul_ctl_q <= mul_ctl_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_add_q <= mul_add_d;
      dat_q     <= dat_d;
    end
  end

endmodule
